// File: rtl/md_unit.sv
// md_unit: multi-cycle MIPS multiply/divide unit owning HI/LO; results are computed at launch
// and committed to HI/LO after the configured busy period.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_E,
  input  logic [31:0] RS_E,
  input  logic [31:0] RT_E,
  input  logic [31:0] instr_D,
  output logic        busy,
  output logic        start,
  output logic        md_stall,
  output logic [31:0] hilo_rd,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] phi_q, phi_d, plo_q, plo_d;
  logic [5:0]  fn;
  logic        r_type, is_mul, is_div, is_mfhi, is_mflo, is_mthi, is_mtlo, sgn;
  logic        a_neg, b_neg;
  logic [63:0] prod;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, quo, rem, div_hi, div_lo;
  logic        unused_bits;
  function automatic logic is_md(input logic [31:0] x);
    return x[31:26] == 6'd0 && (x[5:0] inside {6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B});
  endfunction
  assign unused_bits = ^{instr_E[25:6], instr_D[25:6]};
  assign fn      = instr_E[5:0];
  assign r_type  = instr_E[31:26] == 6'd0;
  assign is_mul  = r_type & (fn == 6'h18 | fn == 6'h19);
  assign is_div  = r_type & (fn == 6'h1A | fn == 6'h1B);
  assign is_mfhi = r_type & fn == 6'h10;
  assign is_mthi = r_type & fn == 6'h11;
  assign is_mflo = r_type & fn == 6'h12;
  assign is_mtlo = r_type & fn == 6'h13;
  assign sgn     = ~fn[0];
  // Signed divide runs on magnitudes; the overflow case 0x80000000/-1 falls out as 0x80000000 rem 0.
  always_comb begin
    prod   = sgn ? {{32{RS_E[31]}}, RS_E} * {{32{RT_E[31]}}, RT_E} : {32'd0, RS_E} * {32'd0, RT_E};
    a_neg  = sgn & RS_E[31];
    b_neg  = sgn & RT_E[31];
    a_mag  = a_neg ? -RS_E : RS_E;
    b_mag  = b_neg ? -RT_E : RT_E;
    q_mag  = b_mag == 32'd0 ? 32'd0 : a_mag / b_mag;
    r_mag  = b_mag == 32'd0 ? 32'd0 : a_mag % b_mag;
    quo    = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem    = a_neg ? -r_mag : r_mag;
    div_hi = RT_E == 32'd0 ? RS_E : rem;
    div_lo = RT_E == 32'd0 ? 32'hFFFF_FFFF : quo;
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    phi_d   = phi_q;
    plo_d   = plo_q;
    start   = 1'b0;
    if (state_q == IDLE) begin
      if (is_mul | is_div) begin
        start   = 1'b1;
        phi_d   = is_mul ? prod[63:32] : div_hi;
        plo_d   = is_mul ? prod[31:0] : div_lo;
        cnt_d   = is_mul ? 32'(MULT_CYCLES - 1) : 32'(DIV_CYCLES - 1);
        state_d = BUSY;
      end
      hi_d = is_mthi ? RS_E : hi_q;
      lo_d = is_mtlo ? RS_E : lo_q;
    end else begin
      cnt_d   = cnt_q == 32'd0 ? 32'd0 : cnt_q - 32'd1;
      hi_d    = cnt_q == 32'd0 ? phi_q : hi_q;
      lo_d    = cnt_q == 32'd0 ? plo_q : lo_q;
      state_d = cnt_q == 32'd0 ? IDLE : BUSY;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      phi_q   <= '0;
      plo_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      phi_q   <= phi_d;
      plo_q   <= plo_d;
    end
  end
  assign busy     = state_q == BUSY;
  assign md_stall = (busy | start) & is_md(instr_D);
  assign hilo_rd  = (state_q == IDLE && is_mfhi) ? hi_q : (state_q == IDLE && is_mflo) ? lo_q : 32'd0;
  assign hi       = hi_q;
  assign lo       = lo_q;
endmodule

// File: doc/md_unit.md
# md_unit

Multi-cycle multiply/divide unit for the execute stage. It reads `instr_E`, `RS_E` and `RT_E` from the ID/EX register and executes MIPS `mult`/`multu`/`div`/`divu`/`mthi`/`mtlo`/`mfhi`/`mflo`. It owns the HI/LO registers. It raises `md_stall` so that the hazard unit holds any multiply/divide instruction in D while an operation is in flight.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: busy cycles for `mult`/`multu` (≥1).
- `DIV_CYCLES`, default 10: busy cycles for `div`/`divu` (≥1).

Ports:
- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `instr_E`  in  32  instruction currently in E (0 = bubble)
- `RS_E`  in  32  rs operand, already forwarded
- `RT_E`  in  32  rt operand, already forwarded
- `instr_D`  in  32  instruction currently in D
- `busy`  out  1  registered; high while an operation is in flight
- `start`  out  1  combinational; an MD operation launches this cycle
- `md_stall`  out  1  combinational; `(busy | start) & is_md(instr_D)`
- `hilo_rd`  out  32  combinational; HI for `mfhi` in E, LO for `mflo` in E, else 0
- `hi`  out  32  current HI register
- `lo`  out  32  current LO register

## Operation
- **Decode.** `is_md(x)` = `x[31:26]==0` and `x[5:0]` ∈ {0x10 mfhi, 0x11 mthi, 0x12 mflo, 0x13 mtlo, 0x18 mult, 0x19 multu, 0x1A div, 0x1B divu}.
- **States.** IDLE and BUSY, plus a down-counter `cnt`.
- **IDLE, `instr_E` is mult/multu/div/divu.**
  - `start`=1.
  - Compute the result from `RS_E`/`RT_E` and capture it into pending HI/LO registers.
  - Load `cnt` = N−1, where N = `MULT_CYCLES` or `DIV_CYCLES`.
  - Go to BUSY.
- **BUSY.**
  - Decrement `cnt` each cycle.
  - When `cnt`==0, write pending→HI/LO and return to IDLE.
- **mthi/mtlo in E while IDLE.** HI←`RS_E` or LO←`RS_E` at the end of that cycle. No BUSY, `start`=0.
- **Any MD instruction in E while `busy`=1.** Ignored: no state change and `hilo_rd`=0. `md_stall` guarantees this does not happen in the integrated pipeline. The bench flags it as a protocol error.
- **Arithmetic.**
  - `mult`: signed 32×32→64. `multu`: unsigned. Result {HI,LO}.
  - `div`: LO = quotient truncated toward zero; HI = remainder, carrying the sign of the dividend.
  - `divu`: unsigned quotient/remainder.
  - Overflow `div` of 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divide by zero (signed or unsigned): HI=`RS_E`, LO=0xFFFFFFFF.
- **Reads.** `hilo_rd` reflects the HI/LO register contents in the current cycle. An `mthi` followed by `mfhi` in the next E cycle returns the new value.
- **Bubbles.** A bubble (`instr_E`=0, as inserted by an ID/EX clear) decodes as `sll $0` and has no effect.

## Timing
- **Reset.** `busy`=0, state IDLE, `cnt`=0, HI=0, LO=0, pending=0. Combinational outputs then follow their inputs.
- **Reset mid-operation.** Aborts the operation. The pending result is discarded and HI/LO are cleared on the same edge.
- **Launch timing.** For an operation in E during cycle T:
  - `start`=1 in T only.
  - `busy`=1 in cycles T+1..T+N.
  - HI/LO hold their new value from T+N+1 onward.
  - HI/LO are unchanged through T+N.
- **`busy` fall and new launch.** `busy` falls at the edge ending T+N. An MD instruction in E at T+N+1 launches normally.
- **`md_stall`.** High in T..T+N whenever `instr_D` is an MD instruction. It is therefore never high in T+N+1, which is the first cycle the held instruction may enter E.
- **mthi/mtlo.** Latency 1: written at the end of the E cycle.

## Test plan
- **Signed multiply.** `mult`, RS=0xFFFFFFFD (−3), RT=5 at T. Required:
  - `start`=1 at T.
  - `busy`=1 for T+1..T+5.
  - At T+6: HI=0xFFFFFFFF, LO=0xFFFFFFF1.
  - `mfhi` in E at T+6 gives `hilo_rd`=0xFFFFFFFF.
- **Unsigned and signed divide.**
  - `divu` 100/7 → after 10 busy cycles LO=14, HI=2.
  - `div` 0xFFFFFFF9 (−7) / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- **Divide by zero and overflow.**
  - `divu` 0x12345678/0 → HI=0x12345678, LO=0xFFFFFFFF.
  - `div` 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- **Stall and move.**
  - `mult` at T with `mflo` held in D → `md_stall`=1 for T..T+5, 0 at T+6.
  - `mtlo` RS=0xA5A5A5A5 followed by `mflo` → `hilo_rd`=0xA5A5A5A5 one cycle later, with `busy` never asserted.
- **Reset mid-operation.** `div` at T, `reset` at T+4 → at T+5 `busy`=0, HI=LO=0. A subsequent `multu` 0xFFFFFFFF×2 → HI=1, LO=0xFFFFFFFE.
